// File: rtl/cv32e40x_bch_pred_ctrl.sv
// cv32e40x_bch_pred_ctrl
//   Dynamic branch-direction predictor controller for the ID stage.
//   A table of 2-bit saturating counters, indexed by pc[IDX_W:1], supplies the
//   taken/not-taken prediction for conditional branches in ID. After reset or
//   flush, an INIT phase writes CTR_INIT to every entry. Until that finishes,
//   lookups fall back to static backward-taken. EX resolutions train the
//   table. A saturating 16-bit counter tracks mispredicts.
//
//   Optional feature (macro CV32E40X_BCH_PRED_BYPASS_EN):
//     defined   - a same-cycle RUN update to the lookup index forwards the
//                 post-update counter to the prediction.
//     undefined - read-before-write; no bypass mux is built.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush_i              re-initialise the whole table
//   lookup_valid_i       ID holds a conditional branch
//   lookup_pc_i          PC of that branch
//   lookup_imm_sign_i    branch offset sign (static fallback)
//   bch_prediction_id_o  predicted taken (combinational)
//   pred_dynamic_o       prediction came from the table (combinational)
//   upd_valid_i          EX resolved a conditional branch
//   upd_pc_i             PC of the resolved branch
//   upd_taken_i          actual outcome
//   upd_mispredict_i     ID prediction was wrong
//   init_done_o          table valid (FSM in RUN), registered
//   mispred_cnt_o        saturating mispredict count, registered
module cv32e40x_bch_pred_ctrl #(
  parameter int unsigned BHT_DEPTH = 16,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  input  logic        lookup_imm_sign_i,
  output logic        bch_prediction_id_o,
  output logic        pred_dynamic_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic        upd_mispredict_i,
  output logic        init_done_o,
  output logic [15:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] init_ptr_q;
  logic             init_done_q;
  logic [15:0]      mispred_cnt_q;
  logic [1:0]       ctr_q [BHT_DEPTH];

  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_en;
  logic [1:0]       upd_ctr_cur;
  logic [1:0]       upd_ctr_d;

  // Only pc[IDX_W:1] selects an entry; the remaining bits are unused.
  logic unused_pc;
  assign unused_pc = ^{lookup_pc_i[31:IDX_W+1], lookup_pc_i[0],
                       upd_pc_i[31:IDX_W+1], upd_pc_i[0]};

  assign lkp_idx = lookup_pc_i[IDX_W:1];
  assign upd_idx = upd_pc_i[IDX_W:1];

  // A flush in the same cycle wins over the update.
  assign upd_en = (state_q == ST_RUN) && upd_valid_i && !flush_i;

  always_comb begin
    upd_ctr_cur = ctr_q[upd_idx];
    upd_ctr_d   = upd_ctr_cur;
    if (upd_taken_i) begin
      if (upd_ctr_cur != 2'b11) upd_ctr_d = upd_ctr_cur + 2'b01;
    end else begin
      if (upd_ctr_cur != 2'b00) upd_ctr_d = upd_ctr_cur - 2'b01;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_ptr_q    <= '0;
      init_done_q   <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_valid_i && upd_mispredict_i && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + 16'd1;
      end
      case (state_q)
        ST_INIT: begin
          if (flush_i) begin
            init_ptr_q <= '0;
          end else if (init_ptr_q == LAST_IDX) begin
            init_ptr_q  <= '0;
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            init_ptr_q <= init_ptr_q + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_INIT;
          init_ptr_q  <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Counter table: no reset, the INIT sweep writes every entry before RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        ctr_q[init_ptr_q] <= CTR_INIT;
      end else if (upd_en) begin
        ctr_q[upd_idx] <= upd_ctr_d;
      end
    end
  end

  always_comb begin
    bch_prediction_id_o = 1'b0;
    pred_dynamic_o      = 1'b0;
    if (lookup_valid_i) begin
      if (state_q == ST_RUN) begin
        pred_dynamic_o = 1'b1;
`ifdef CV32E40X_BCH_PRED_BYPASS_EN
        if (upd_en && (upd_idx == lkp_idx)) begin
          bch_prediction_id_o = upd_ctr_d[1];
        end else begin
          bch_prediction_id_o = ctr_q[lkp_idx][1];
        end
`else
        bch_prediction_id_o = ctr_q[lkp_idx][1];
`endif
      end else begin
        // Static backward-taken while the table is not yet valid.
        bch_prediction_id_o = lookup_imm_sign_i;
      end
    end
  end

  assign init_done_o   = init_done_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_cv32e40x_bch_pred_ctrl.sv
module tb_cv32e40x_bch_pred_ctrl;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_imm_sign_i;
  logic        bch_prediction_id_o;
  logic        pred_dynamic_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_mispredict_i;
  logic        init_done_o;
  logic [15:0] mispred_cnt_o;

  int unsigned n_pass;
  int unsigned n_total;
  logic [15:0] model_cnt;

`ifdef CV32E40X_BCH_PRED_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  cv32e40x_bch_pred_ctrl #(
    .BHT_DEPTH (16),
    .CTR_INIT  (2'b01)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .lookup_valid_i      (lookup_valid_i),
    .lookup_pc_i         (lookup_pc_i),
    .lookup_imm_sign_i   (lookup_imm_sign_i),
    .bch_prediction_id_o (bch_prediction_id_o),
    .pred_dynamic_o      (pred_dynamic_o),
    .upd_valid_i         (upd_valid_i),
    .upd_pc_i            (upd_pc_i),
    .upd_taken_i         (upd_taken_i),
    .upd_mispredict_i    (upd_mispredict_i),
    .init_done_o         (init_done_o),
    .mispred_cnt_o       (mispred_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        um;
    logic        lv;
    logic [31:0] lpc;
    logic        ls;
    logic        ep;
    logic        ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic um,
                              logic lv, logic [31:0] lpc, logic ls,
                              logic ep, logic ed);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.um = um;
    v.lv = lv; v.lpc = lpc; v.ls = ls; v.ep = ep; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock; inputs are driven right after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; lookup_valid_i = 1'b0; lookup_pc_i = '0; lookup_imm_sign_i = 1'b0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_mispredict_i = 1'b0;
  endtask

  task automatic do_lookup(input string name, input logic [31:0] pc, input logic ep, input logic ed);
    lookup_valid_i = 1'b1; lookup_pc_i = pc; lookup_imm_sign_i = 1'b0;
    #1;
    chk({name, "_pred"}, {31'd0, bch_prediction_id_o}, {31'd0, ep});
    chk({name, "_dyn"}, {31'd0, pred_dynamic_o}, {31'd0, ed});
    lookup_valid_i = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic mis);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = taken; upd_mispredict_i = mis;
    step();
    if (mis && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    upd_valid_i = 1'b0; upd_mispredict_i = 1'b0;
  endtask

  // Called in the first cycle after the edge that entered INIT; returns in
  // the first RUN cycle. Checks init_done_o over the whole window.
  task automatic init_window(input string name);
    for (int c = 0; c <= 16; c++) begin
      #1;
      chk($sformatf("%s_done_c%0d", name, c), {31'd0, init_done_o}, {31'd0, (c >= 16)});
      if (c < 16) step();
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    model_cnt = '0;
    idle_inputs();
    rst = 1'b1;

    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h100, 1, 0,   1));
    vecs.push_back(mk(1, 32'h100, 1, 0, 1, 32'h100, 0, BYP, 1));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h100, 0, 1,   1));
    vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h100, 1, 0,   0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h100, 0, 1,   1));
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 32'h102, 0, 0,   1));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h100, 0, 1,   1));
    vecs.push_back(mk(1, 32'h100, 0, 1, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h100, 0, 0,   1));
    vecs.push_back(mk(1, 32'h120, 1, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h100, 0, 1,   1));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h121, 0, 1,   1));
    vecs.push_back(mk(1, 32'h120, 0, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h101, 0, 0,   1));
    vecs.push_back(mk(1, 32'h11E, 1, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h01E, 0, 1,   1));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(1, 32'h104, 0, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h104, 0, 0,   1));
    vecs.push_back(mk(1, 32'h104, 1, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h104, 0, 0,   1));
    vecs.push_back(mk(1, 32'h104, 1, 0, 0, 32'h0,   0, 0,   0));
    vecs.push_back(mk(0, 32'h0,   0, 0, 1, 32'h104, 0, 1,   1));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_done", {31'd0, init_done_o}, 32'd0);
    chk("rst_cnt", {16'd0, mispred_cnt_o}, 32'd0);
    chk("rst_pred", {31'd0, bch_prediction_id_o}, 32'd0);
    chk("rst_dyn", {31'd0, pred_dynamic_o}, 32'd0);
    rst = 1'b0;

    // Initial INIT window with a static lookup at cycle 5
    for (int c = 0; c <= 16; c++) begin
      #1;
      chk($sformatf("init0_done_c%0d", c), {31'd0, init_done_o}, {31'd0, (c >= 16)});
      if (c == 5) begin
        lookup_valid_i = 1'b1; lookup_pc_i = 32'h100; lookup_imm_sign_i = 1'b1;
        #1;
        chk("init_static_pred", {31'd0, bch_prediction_id_o}, 32'd1);
        chk("init_static_dyn", {31'd0, pred_dynamic_o}, 32'd0);
        idle_inputs();
      end
      if (c < 16) step();
    end

    // Table-driven RUN vectors
    foreach (vecs[i]) begin
      upd_valid_i = vecs[i].uv; upd_pc_i = vecs[i].upc;
      upd_taken_i = vecs[i].ut; upd_mispredict_i = vecs[i].um;
      lookup_valid_i = vecs[i].lv; lookup_pc_i = vecs[i].lpc;
      lookup_imm_sign_i = vecs[i].ls;
      #1;
      chk($sformatf("vec%0d_pred", i), {31'd0, bch_prediction_id_o}, {31'd0, vecs[i].ep});
      chk($sformatf("vec%0d_dyn", i), {31'd0, pred_dynamic_o}, {31'd0, vecs[i].ed});
      chk($sformatf("vec%0d_cnt", i), {16'd0, mispred_cnt_o}, {16'd0, model_cnt});
      step();
      if (vecs[i].uv && vecs[i].um) model_cnt = model_cnt + 16'd1;
      idle_inputs();
    end

    // Flush mid-RUN with entry 0 saturated at 11 and an update in the flush cycle
    do_update(32'h100, 1'b1, 1'b0);
    do_update(32'h100, 1'b1, 1'b0);
    do_lookup("pre_flush", 32'h100, 1'b1, 1'b1);
    flush_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1;
    #1;
    chk("flush_cycle_done", {31'd0, init_done_o}, 32'd1);
    step();
    idle_inputs();
    for (int c = 0; c <= 16; c++) begin
      #1;
      chk($sformatf("flush_done_c%0d", c), {31'd0, init_done_o}, {31'd0, (c >= 16)});
      if (c == 3) begin
        lookup_valid_i = 1'b1; lookup_pc_i = 32'h100; lookup_imm_sign_i = 1'b0;
        #1;
        chk("flush_static_pred", {31'd0, bch_prediction_id_o}, 32'd0);
        chk("flush_static_dyn", {31'd0, pred_dynamic_o}, 32'd0);
        lookup_valid_i = 1'b0;
      end
      if (c == 5) begin
        // Dropped table update (entry 0 already re-written), but it still counts.
        upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1; upd_mispredict_i = 1'b1;
      end
      if (c < 16) step();
      if (c == 5) begin
        model_cnt = model_cnt + 16'd1;
        idle_inputs();
      end
    end
    do_lookup("post_flush_0", 32'h100, 1'b0, 1'b1);
    do_lookup("post_flush_2", 32'h104, 1'b0, 1'b1);
    #1;
    chk("post_flush_cnt", {16'd0, mispred_cnt_o}, {16'd0, model_cnt});

    // Flush during INIT restarts the sweep
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (4) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    init_window("reflush");

    // Mispredict counter saturation
    upd_valid_i = 1'b1; upd_pc_i = 32'h108; upd_taken_i = 1'b1; upd_mispredict_i = 1'b1;
    while (model_cnt != 16'hFFFE) begin
      step();
      model_cnt = model_cnt + 16'd1;
    end
    #1;
    chk("cnt_fffe", {16'd0, mispred_cnt_o}, 32'h0000FFFE);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk($sformatf("cnt_sat%0d", k), {16'd0, mispred_cnt_o}, 32'h0000FFFF);
    end
    idle_inputs();

    // Reset mid-INIT at init_ptr = 7
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    #1;
    chk("midinit_rst_cnt", {16'd0, mispred_cnt_o}, 32'd0);
    chk("midinit_rst_done", {31'd0, init_done_o}, 32'd0);
    rst = 1'b0;
    init_window("rst_restart");
    do_lookup("rst_restart_lkp", 32'h11E, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
